fios_res_collector: RTL
=======================

// Module: fios_res_collector
// PURPOSE
//  Downstream of the FIOS PE cascade: captures the s result words pushed LSW-first by the last PE
//  (one word per RES_push pulse, delayed through the chain) and assembles them into one s*w-bit
//  Montgomery product. Ping-pong double buffer lets the next multiplication stream in while the
//  previous result waits on a valid/ready consumer.
// PARAMETERS
//  s      16  words per operand/result; matches FIOS control s
//  w      17  bits per result word (DSP limb width)
// PORTS
//  clock_i       in   1      single clock, all logic rising-edge
//  reset_n_i     in   1      synchronous, active-low reset
//  res_push_i    in   1      result word valid from last PE (delayed RES_push)
//  res_word_i    in   w      result word, LSW first
//  res_valid_o   out  1      assembled result available
//  res_ready_i   in   1      consumer accepts result when res_valid_o & res_ready_i
//  res_o         out  s*w    assembled result; word k at bits [k*w +: w]
//  busy_o        out  1      write buffer partially filled (0 < word count < s)
//  overflow_o    out  1      sticky: push arrived with both buffers full
// BEHAVIOUR
//  Reset (reset_n_i=0 at an edge): wr_sel=0, rd_sel=0, word_cnt=0, full[1:0]=0, res_valid_o=0,
//   busy_o=0, overflow_o=0; buffer contents not reset; res_o=0 while res_valid_o=0 (output gated).
//   Reset mid-fill discards partial word count; mid-handshake drops the pending result.
//  Write FSM (states FILL, STALL):
//   FILL: on res_push_i, buf[wr_sel][word_cnt*w +: w] <= res_word_i, word_cnt++.
//    On push with word_cnt==s-1: word_cnt<=0, full[wr_sel]<=1, wr_sel toggles;
//    go STALL if full[~wr_sel] will still be set next cycle, else stay FILL.
//   STALL: both buffers full; res_push_i drops the word and sets overflow_o (sticky until reset).
//    Leaves to FILL the cycle after a read handshake frees a buffer.
//  Read side: res_valid_o = full[rd_sel]; res_o = buf[rd_sel]. Handshake at edge with
//   res_valid_o & res_ready_i: full[rd_sel]<=0, rd_sel toggles.
//  Latency: res_valid_o high the cycle after the edge capturing word s-1 (1 cycle).
//  res_o/res_valid_o stable while res_valid_o & ~res_ready_i (no retraction).
//  Simultaneous completion of buf X and read of buf Y in same edge: both applied; no stall.
//  Push with word_cnt<s-1 never blocked by read side; read never blocked by write side.
//  busy_o = (word_cnt != 0).
//  Throughput: one result per s push cycles sustained if consumer ready within s cycles.
// CONFIGURATION
//  Macro RES_COUNT_CHECK_EN:
//   defined: extra input done_i (1, control done delayed to this stage) and sticky output
//    count_err_o (1, reset 0). At done_i, error if word count (including push same cycle) != 0
//    after wrap, i.e. partial result; sets count_err_o and clears word_cnt (partial discarded,
//    full flag not set).
//   undefined: ports absent; word count alone delimits results.
// STRUCTURE
//  Package fios_pkg: FSM state typedef (FILL, STALL), word-index width $clog2(s) helper,
//   shared s/w defaults.
//  One sub-module: fios_res_buffer (single s*w buffer, word-indexed write enable, full flag);
//   instantiated twice; top holds FSM, pointers, handshake, flags.
// TESTING
//  1) Reset, push 16 words 0x00001..0x00010 consecutive, ready=1 -> res_valid_o 1 cycle after
//     word 16, res_o word k = k+1, handshake next edge, valid drops.
//  2) ready=0, push two full results A,B -> busy_o 0, both buffers full, FSM STALL; raise ready
//     -> A then B delivered in order, no overflow.
//  3) Both full, push 1 more word -> overflow_o=1 sticky, word dropped; later results unaffected.
//  4) Word 16 of B captured same edge as A handshake -> B valid next cycle, no bubble/stall.
//  5) Reset asserted after 7 pushes -> busy_o=0, valid=0; next 16 pushes form clean result.
//  6) RES_COUNT_CHECK_EN: done_i after 15 pushes -> count_err_o=1, no res_valid_o; without
//     macro, same stimulus leaves word_cnt=15.

Source files
------------

// File: rtl/fios_pkg.sv
// ============================================================================
// Module  : fios_pkg
// Brief   : Shared defaults, write-FSM state encoding and index-width helper
//           for the FIOS result collector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fios_pkg;

  localparam int S_DEF = 16;
  localparam int W_DEF = 17;

  typedef logic [0:0] wr_state_t;

  localparam wr_state_t ST_FILL  = 1'b0;
  localparam wr_state_t ST_STALL = 1'b1;

  // Never narrower than one bit, so a single-word configuration still elaborates.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fios_res_buffer.sv
// ============================================================================
// Module  : fios_res_buffer
// Brief   : One S*W result buffer with word-indexed write and a full flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fios_res_buffer
  import fios_pkg::*;
#(
  parameter int S  = S_DEF,
  parameter int W  = W_DEF,
  parameter int IW = idx_width(S)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wr_en,
  input  logic [IW-1:0]   i_wr_idx,
  input  logic [W-1:0]    i_wr_data,
  input  logic            i_set_full,
  input  logic            i_clr_full,
  output logic [S*W-1:0]  o_data,
  output logic            o_full
);

  logic [S*W-1:0] data_q, data_d;
  logic           full_q, full_d;

  always_comb begin
    data_d = data_q;
    for (int k = 0; k < S; k++) begin
      if (i_wr_en && (i_wr_idx == IW'(k))) begin
        data_d[k*W +: W] = i_wr_data;
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (i_clr_full) full_d = 1'b0;
    if (i_set_full) full_d = 1'b1;
  end

  // Storage is deliberately left unreset; the full flag alone qualifies it.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) full_q <= 1'b0;
    else        full_q <= full_d;
  end

  assign o_data = data_q;
  assign o_full = full_q;

endmodule

`default_nettype wire

// File: rtl/fios_res_collector.sv
// ============================================================================
// Module  : fios_res_collector
// Brief   : Assembles S result words from the last FIOS PE into one S*W
//           product through a ping-pong buffer with a valid/ready output.
//           Optional RES_COUNT_CHECK_EN adds done_i / count_err_o.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fios_res_collector
  import fios_pkg::*;
#(
  parameter int S = S_DEF,
  parameter int W = W_DEF
) (
  input  logic            clock_i,
  input  logic            reset_n_i,
  input  logic            res_push_i,
  input  logic [W-1:0]    res_word_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [S*W-1:0]  res_o,
  output logic            busy_o,
  output logic            overflow_o
`ifdef RES_COUNT_CHECK_EN
  ,
  input  logic            done_i,
  output logic            count_err_o
`endif
);

  localparam int IW = idx_width(S);

  wr_state_t      state_q, state_d;
  logic           wr_sel_q, wr_sel_d;
  logic           rd_sel_q, rd_sel_d;
  logic [IW-1:0]  word_cnt_q, word_cnt_d;
  logic           overflow_q, overflow_d;

  logic [1:0]     w_full;
  logic [S*W-1:0] w_buf_data [2];
  logic [1:0]     w_wr_en, w_set_full, w_clr_full;
  logic           w_rd_valid, w_hs, w_push_acc, w_last;

  assign w_rd_valid = w_full[rd_sel_q];
  assign w_hs       = w_rd_valid & res_ready_i;
  assign w_push_acc = res_push_i & (state_q == ST_FILL);
  assign w_last     = w_push_acc & (word_cnt_q == IW'(S-1));

  always_comb begin
    w_wr_en    = '0;
    w_set_full = '0;
    w_clr_full = '0;
    w_wr_en[wr_sel_q]    = w_push_acc;
    w_set_full[wr_sel_q] = w_last;
    w_clr_full[rd_sel_q] = w_hs;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    fios_res_buffer #(.S(S), .W(W), .IW(IW)) u_buf (
      .clk        (clock_i),
      .rst_n      (reset_n_i),
      .i_wr_en    (w_wr_en[gi]),
      .i_wr_idx   (word_cnt_q),
      .i_wr_data  (res_word_i),
      .i_set_full (w_set_full[gi]),
      .i_clr_full (w_clr_full[gi]),
      .o_data     (w_buf_data[gi]),
      .o_full     (w_full[gi])
    );
  end

  always_comb begin
    state_d    = state_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    word_cnt_d = word_cnt_q;
    overflow_d = overflow_q;

    if (w_push_acc) begin
      word_cnt_d = w_last ? '0 : word_cnt_q + IW'(1);
    end
    if (w_last) begin
      wr_sel_d = ~wr_sel_q;
    end
    if (w_hs) begin
      rd_sel_d = ~rd_sel_q;
    end

    case (state_q)
      ST_FILL: begin
        // Stall only if the buffer we switch to stays full past this edge.
        if (w_last && w_full[~wr_sel_q] && !(w_hs && (rd_sel_q == ~wr_sel_q))) begin
          state_d = ST_STALL;
        end
      end
      default: begin
        if (res_push_i) overflow_d = 1'b1;
        if (w_hs)       state_d    = ST_FILL;
      end
    endcase

`ifdef RES_COUNT_CHECK_EN
    if (done_i) word_cnt_d = '0;
`endif
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_FILL;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      word_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      word_cnt_q <= word_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef RES_COUNT_CHECK_EN
  logic count_err_q, count_err_d;
  logic [IW-1:0] w_cnt_after_push;

  always_comb begin
    w_cnt_after_push = word_cnt_q;
    if (w_push_acc) w_cnt_after_push = w_last ? '0 : word_cnt_q + IW'(1);
    count_err_d = count_err_q;
    if (done_i && (w_cnt_after_push != '0)) count_err_d = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) count_err_q <= 1'b0;
    else            count_err_q <= count_err_d;
  end

  assign count_err_o = count_err_q;
`endif

  assign res_valid_o = w_rd_valid;
  assign res_o       = w_rd_valid ? w_buf_data[rd_sel_q] : '0;
  assign busy_o      = (word_cnt_q != '0);
  assign overflow_o  = overflow_q;

endmodule

`default_nettype wire
